axixl_lite_traffic_gen: RTL

Parametrised AXI4-Lite master traffic generator and self-checker; the successor to the single-shot example master inside the axixl IP. On a start pulse it writes an incrementing data pattern to a configurable address window, then optionally reads it back and compares. It reports done, error, a mismatch count and the first failing index to the block-design level. It sits behind an AXI VIP slave or interconnect in the bfm_design bench and in hardware self-test builds.

---
 rtl/axixl_lite_traffic_gen.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axixl_lite_traffic_gen.sv
// AXI4-Lite master traffic generator: writes an incrementing pattern to an address
// window, optionally reads it back, and reports mismatch/timeout status.
module axixl_lite_traffic_gen #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_NUM_TXN = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0,
  parameter logic [C_M_AXI_DATA_WIDTH-1:0] C_SEED = C_M_AXI_DATA_WIDTH'(1),
  parameter int C_MODE = 0,
  parameter int C_TIMEOUT = 1024
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic                              INIT_AXI_TXN,
  output logic                              TXN_DONE,
  output logic                              ERROR,
  output logic                              BUSY,
  output logic [15:0]                       ERR_COUNT,
  output logic [7:0]                        FIRST_ERR_IDX,
  output logic                              TIMEOUT_FLAG,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int AW       = C_M_AXI_ADDR_WIDTH;
  localparam int DW       = C_M_AXI_DATA_WIDTH;
  localparam int ADDR_LSB = $clog2(DW / 8);
  localparam int TW       = $clog2(C_TIMEOUT + 1);
  localparam logic [7:0]    LAST_IDX = 8'(C_NUM_TXN - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(C_TIMEOUT);

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;

  state_t          state_q, state_d;
  logic [7:0]      idx_q, idx_d;
  logic            issued_q, issued_d;
  logic            init_q, init_dly_q;
  logic            awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic            arvalid_q, arvalid_d, rready_q, rready_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic            txn_done_q, txn_done_d, error_q, error_d, busy_q, busy_d;
  logic [15:0]     err_cnt_q, err_cnt_d;
  logic [7:0]      first_idx_q, first_idx_d;
  logic            tmo_flag_q, tmo_flag_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;

  logic            start_rise, beat_fail, waiting;
  logic [AW-1:0]   beat_addr;
  logic [DW-1:0]   beat_data;

  assign start_rise = init_q & ~init_dly_q;
  assign beat_addr  = C_BASE_ADDR + (AW'(idx_q) << ADDR_LSB);
  assign beat_data  = C_SEED + DW'(idx_q);
  assign waiting    = state_q inside {WR_ADDR, WR_RESP, RD_ADDR, RD_DATA};

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    issued_d    = issued_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    addr_d      = addr_q;
    data_d      = data_q;
    txn_done_d  = txn_done_q;
    error_d     = error_q;
    busy_d      = busy_q;
    err_cnt_d   = err_cnt_q;
    first_idx_d = first_idx_q;
    tmo_flag_d  = tmo_flag_q;
    tmo_cnt_d   = tmo_cnt_q;
    beat_fail   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start_rise) begin
          state_d     = (C_MODE == 2) ? RD_ADDR : WR_ADDR;
          idx_d       = '0;
          issued_d    = 1'b0;
          txn_done_d  = 1'b0;
          busy_d      = 1'b1;
          error_d     = 1'b0;
          err_cnt_d   = '0;
          first_idx_d = '1;
          tmo_flag_d  = 1'b0;
        end
      end
      // First cycle in the state loads the beat and raises VALID; handshakes follow.
      WR_ADDR: begin
        if (!issued_q) begin
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          issued_d  = 1'b1;
          addr_d    = beat_addr;
          data_d    = beat_data;
        end else begin
          if (M_AXI_AWREADY) awvalid_d = 1'b0;
          if (M_AXI_WREADY)  wvalid_d  = 1'b0;
          if (!awvalid_d && !wvalid_d) begin
            state_d  = WR_RESP;
            bready_d = 1'b1;
            issued_d = 1'b0;
          end
        end
      end
      WR_RESP: begin
        if (M_AXI_BVALID) begin
          bready_d  = 1'b0;
          beat_fail = (M_AXI_BRESP != 2'b00);
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = (C_MODE == 0) ? RD_ADDR : DONE;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = WR_ADDR;
          end
        end
      end
      RD_ADDR: begin
        if (!issued_q) begin
          arvalid_d = 1'b1;
          issued_d  = 1'b1;
          addr_d    = beat_addr;
          data_d    = beat_data;
        end else if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          issued_d  = 1'b0;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (M_AXI_RVALID) begin
          rready_d  = 1'b0;
          beat_fail = (M_AXI_RRESP != 2'b00) || (M_AXI_RDATA != data_q);
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = RD_ADDR;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == DONE && state_q != DONE) begin
      txn_done_d = 1'b1;
      busy_d     = 1'b0;
    end

    if (beat_fail) begin
      error_d = 1'b1;
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      if (first_idx_q == 8'hFF)  first_idx_d = idx_q;
    end

    // The watchdog only flags; VALID stays up so the channel remains AXI-legal.
    if (state_d != state_q) begin
      tmo_cnt_d = '0;
    end else if (waiting && tmo_cnt_q != TMO_MAX) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
      if (tmo_cnt_d == TMO_MAX) begin
        tmo_flag_d = 1'b1;
        error_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      issued_q    <= 1'b0;
      init_q      <= 1'b0;
      init_dly_q  <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      txn_done_q  <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_cnt_q   <= '0;
      first_idx_q <= 8'hFF;
      tmo_flag_q  <= 1'b0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      issued_q    <= issued_d;
      init_q      <= INIT_AXI_TXN;
      init_dly_q  <= init_q;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      txn_done_q  <= txn_done_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
      err_cnt_q   <= err_cnt_d;
      first_idx_q <= first_idx_d;
      tmo_flag_q  <= tmo_flag_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign TXN_DONE      = txn_done_q;
  assign ERROR         = error_q;
  assign BUSY          = busy_q;
  assign ERR_COUNT     = err_cnt_q;
  assign FIRST_ERR_IDX = first_idx_q;
  assign TIMEOUT_FLAG  = tmo_flag_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_WDATA   = data_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule
